// File: rtl/fpu_div_pkg.sv
// rtl/fpu_div_pkg.sv - shared types and constants for the iterative mantissa divider
package fpu_div_pkg;

    localparam int DIV_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one radix-2 restoring division step (combinational)
module div_step
    import fpu_div_pkg::*;
#(
    parameter int W = DIV_W_DEFAULT
) (
    input  logic [W-1:0] p,
    input  logic         q_msb,
    input  logic [W-1:0] d,
    output logic [W-1:0] p_next,
    output logic         q_bit
);

    logic [W:0]   trial;
    logic [W-1:0] p_shifted;

    // The bit shifted out of p is kept as the top bit of the minuend, so a
    // divisor with its MSB set never produces a false success.
    assign trial     = {p, q_msb} - {1'b0, d};
    assign p_shifted = {p[W-2:0], q_msb};
    assign q_bit     = ~trial[W];
    assign p_next    = q_bit ? trial[W-1:0] : p_shifted;

endmodule

// File: rtl/sequential_divider.sv
// rtl/sequential_divider.sv - iterative unsigned restoring divider, W+1 cycle latency
module sequential_divider
    import fpu_div_pkg::*;
#(
    parameter  int W  = DIV_W_DEFAULT,
    localparam int CW = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [W-1:0] Data_A_i,
    input  logic [W-1:0] Data_B_i,
    output logic         busy_o,
    output logic         ready_o,
    output logic [W-1:0] Data_Q_o,
    output logic [W-1:0] Data_R_o,
    output logic         div_zero_o
);

    div_state_t    state;
    logic [W-1:0]  d_reg;
    logic [W-1:0]  q_reg;
    logic [W-1:0]  p_reg;
    logic [CW-1:0] cnt;

    logic [W-1:0]  p_next;
    logic          q_bit;
    logic [W-1:0]  q_next;
    logic          last_iter;
    logic          accept;

    div_step #(.W(W)) u_step (
        .p      (p_reg),
        .q_msb  (q_reg[W-1]),
        .d      (d_reg),
        .p_next (p_next),
        .q_bit  (q_bit)
    );

    assign q_next    = {q_reg[W-2:0], q_bit};
    assign last_iter = (cnt == CW'(W - 1));
    assign accept    = start_i && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            d_reg      <= '0;
            q_reg      <= '0;
            p_reg      <= '0;
            cnt        <= '0;
            busy_o     <= 1'b0;
            ready_o    <= 1'b0;
            Data_Q_o   <= '0;
            Data_R_o   <= '0;
            div_zero_o <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    ready_o <= 1'b0;
                    if (accept) begin
                        d_reg  <= Data_B_i;
                        q_reg  <= Data_A_i;
                        p_reg  <= '0;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                        state  <= CALC;
                    end else begin
                        state  <= IDLE;
                    end
                end
                CALC: begin
                    p_reg <= p_next;
                    q_reg <= q_next;
                    cnt   <= cnt + 1'b1;
                    // Results are published from the final step directly so
                    // they are visible in the same cycle ready_o is.
                    if (last_iter) begin
                        state      <= DONE;
                        busy_o     <= 1'b0;
                        ready_o    <= 1'b1;
                        Data_Q_o   <= q_next;
                        Data_R_o   <= p_next;
                        div_zero_o <= (d_reg == '0);
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy_o  <= 1'b0;
                    ready_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequential_divider.sv
// tb/tb_sequential_divider.sv - directed and table-driven bench for sequential_divider
module tb_sequential_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [W-1:0] Data_A_i;
    logic [W-1:0] Data_B_i;
    logic         busy_o;
    logic         ready_o;
    logic [W-1:0] Data_Q_o;
    logic [W-1:0] Data_R_o;
    logic         div_zero_o;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    vec_t vecs[12];

    sequential_divider #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .Data_A_i   (Data_A_i),
        .Data_B_i   (Data_B_i),
        .busy_o     (busy_o),
        .ready_o    (ready_o),
        .Data_Q_o   (Data_Q_o),
        .Data_R_o   (Data_R_o),
        .div_zero_o (div_zero_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        start_i  = 1'b1;
        Data_A_i = a;
        Data_B_i = b;
        @(posedge clk);
        #1;
        start_i  = 1'b0;
    endtask

    // Called one step after the accepting edge; returns sampled just after the ready edge.
    task automatic wait_ready(input string tag);
        bit got;
        int n;
        int busy_bad;
        got      = 1'b0;
        n        = 0;
        busy_bad = 0;
        while (!got && n <= W + 8) begin
            if (ready_o === 1'b1) begin
                got = 1'b1;
            end else begin
                if (busy_o !== 1'b1) busy_bad++;
                @(posedge clk);
                #1;
                n++;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no ready_o within %0d cycles", tag, W + 8);
        end
        check({tag, "_latency"}, W'(n), W'(W));
        check({tag, "_busy_in_calc"}, W'(busy_bad), '0);
        check({tag, "_busy_at_ready"}, W'(busy_o), '0);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic ez, input string tag);
        start_op(a, b);
        wait_ready(tag);
        check({tag, "_q"}, Data_Q_o, eq);
        check({tag, "_r"}, Data_R_o, er);
        check({tag, "_dz"}, W'(div_zero_o), W'(ez));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1;
        int t2;
        int rdy_cnt;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eq;
        logic [W-1:0] er;

        vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1]  = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
        vecs[2]  = '{32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0};
        vecs[3]  = '{32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
        vecs[4]  = '{32'd5,          32'd9,          32'd0,          32'd5,          1'b0};
        vecs[5]  = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
        vecs[6]  = '{32'd9,          32'd4,          32'd2,          32'd1,          1'b0};
        vecs[7]  = '{32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          32'h7FFF_FFFE,  1'b0};
        vecs[8]  = '{32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFE,  1'b0};
        vecs[9]  = '{32'd1000000,    32'd1000,       32'd1000,       32'd0,          1'b0};
        vecs[10] = '{32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,          1'b1};
        vecs[11] = '{32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE,  32'hF,          1'b0};

        rst      = 1'b1;
        start_i  = 1'b0;
        Data_A_i = '0;
        Data_B_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy",  W'(busy_o),     '0);
        check("reset_ready", W'(ready_o),    '0);
        check("reset_q",     Data_Q_o,       '0);
        check("reset_r",     Data_R_o,       '0);
        check("reset_dz",    W'(div_zero_o), '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, $sformatf("vec%0d", i));
            @(posedge clk);
            #1;
        end

        // start held through all of CALC with operands changing every cycle
        rdy_cnt  = 0;
        start_i  = 1'b1;
        Data_A_i = 32'd50;
        Data_B_i = 32'd3;
        @(posedge clk);
        #1;
        for (int i = 1; i <= W; i++) begin
            Data_A_i = $urandom;
            Data_B_i = $urandom;
            @(posedge clk);
            #1;
            if (ready_o === 1'b1) rdy_cnt++;
        end
        start_i = 1'b0;
        check("hold_ready_at_w", W'(ready_o), 32'd1);
        check("hold_q", Data_Q_o, 32'd16);
        check("hold_r", Data_R_o, 32'd2);
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o === 1'b1) rdy_cnt++;
        end
        check("hold_single_result", W'(rdy_cnt), 32'd1);

        // back-to-back: second start in the DONE cycle
        run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "b2b_first");
        t1 = cyc;
        start_op(32'd9, 32'd4);
        check("b2b_hold_q", Data_Q_o, 32'd14);
        check("b2b_hold_r", Data_R_o, 32'd2);
        check("b2b_no_ready", W'(ready_o), '0);
        wait_ready("b2b_second");
        t2 = cyc;
        check("b2b_spacing", W'(t2 - t1), W'(W + 1));
        check("b2b_q", Data_Q_o, 32'd2);
        check("b2b_r", Data_R_o, 32'd1);
        @(posedge clk);
        #1;

        // reset at iteration 10 with start high
        start_op(32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        rst      = 1'b1;
        start_i  = 1'b1;
        Data_A_i = 32'd77;
        Data_B_i = 32'd5;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        start_i = 1'b0;
        check("rst_busy",  W'(busy_o),     '0);
        check("rst_ready", W'(ready_o),    '0);
        check("rst_q",     Data_Q_o,       '0);
        check("rst_r",     Data_R_o,       '0);
        check("rst_dz",    W'(div_zero_o), '0);
        rdy_cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o === 1'b1 || busy_o === 1'b1) rdy_cnt++;
        end
        check("rst_no_activity", W'(rdy_cnt), '0);
        run_op(32'd7, 32'd2, 32'd3, 32'd1, 1'b0, "post_rst");

        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 10 == 0) b = '0;
            if (i % 10 == 1) begin
                b = b | 32'h0000_0100;
                a = 32'($urandom_range(0, 255));
            end
            if (i % 10 == 2) b = 32'($urandom_range(1, 15));
            if (b == '0) begin
                eq = '1;
                er = a;
            end else begin
                eq = a / b;
                er = a % b;
            end
            run_op(a, b, eq, er, (b == '0), $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
